div_iter: RTL and testbench

- Parametrised iterative integer divider for the RISC-V M extension (DIV/DIVU/REM/REMU); next generation of the core's fixed 32-bit radix-2 divider.
- Adds configurable width and bits-per-cycle, valid/ready handshakes on both request and result, a pipeline flush, an opaque tag, and full RISC-V divide-by-zero and overflow semantics.
- Sits beside the ALU in the execute stage.
- The tag carries the destination register address back to writeback.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_iter_if.sv | 28 ++
 rtl/div_iter_step.sv | 35 +++
 rtl/div_iter.sv | 169 ++++++++++++++++
 tb/tb_div_iter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: funct3 encodings, FSM states
// and the sign-aware magnitude helper.
package div_pkg;

    localparam logic [2:0] DIV_OP_DIV  = 3'b100;
    localparam logic [2:0] DIV_OP_DIVU = 3'b101;
    localparam logic [2:0] DIV_OP_REM  = 3'b110;
    localparam logic [2:0] DIV_OP_REMU = 3'b111;

    // Widest supported XLEN; div_abs works on XLEN_MAX+1 bits so MIN is exact.
    localparam int unsigned DIV_MAXW = 64;

    typedef enum logic [1:0] {
        DIV_ST_IDLE,
        DIV_ST_CALC,
        DIV_ST_DONE
    } div_state_e;

    function automatic logic [DIV_MAXW:0] div_abs(input logic [DIV_MAXW:0] value,
                                                  input logic             is_signed);
        logic [DIV_MAXW:0] mag;
        if (is_signed && value[DIV_MAXW]) mag = -value;
        else                              mag = value;
        return mag;
    endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/result handshake bundle of the divider, including flush and busy.
interface div_iter_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) ();
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       op_i;
    logic [XLEN-1:0]  dividend_i;
    logic [XLEN-1:0]  divisor_i;
    logic [TAG_W-1:0] tag_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [XLEN-1:0]  res_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;

    modport slave (
        input  flush_i, req_valid_i, op_i, dividend_i, divisor_i, tag_i, res_ready_i,
        output req_ready_o, res_valid_o, res_o, tag_o, busy_o
    );

    modport master (
        output flush_i, req_valid_i, op_i, dividend_i, divisor_i, tag_i, res_ready_i,
        input  req_ready_o, res_valid_o, res_o, tag_o, busy_o
    );
endinterface

// File: rtl/div_iter_step.sv
// One CALC cycle of restoring division: STEP chained shift/compare/subtract
// stages over the {remainder, dividend} partial remainder.
module div_iter_step #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 1
) (
    input  logic [2*XLEN-1:0] pr_i,
    input  logic [XLEN:0]     dvs_i,
    output logic [2*XLEN-1:0] pr_o,
    output logic [STEP-1:0]   q_o
);

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN:0]   sh;
    logic [XLEN:0]     upper;
    logic              qbit;

    always_comb begin
        acc   = pr_i;
        q_o   = '0;
        sh    = '0;
        upper = '0;
        qbit  = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            sh    = {acc, 1'b0};
            upper = sh[2*XLEN:XLEN];
            qbit  = (upper >= dvs_i);
            if (qbit) upper = upper - dvs_i;
            q_o[STEP-1-i] = qbit;
            acc   = {upper[XLEN-1:0], sh[XLEN-1:0]};
        end
        pr_o = acc;
    end

endmodule

// File: rtl/div_iter.sv
// Iterative RISC-V M-extension divider (DIV/DIVU/REM/REMU), STEP quotient bits
// per cycle. Optional macro DIV_ITER_EARLY_OUT_EN skips iteration for trivial cases.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned STEP  = 1,
    parameter int unsigned TAG_W = 5
) (
    input logic       clk,
    input logic       rst,
    div_iter_if.slave bus
);

    localparam int unsigned NCYC  = XLEN / STEP;
    localparam int unsigned CNT_W = $clog2(NCYC + 1);
    localparam int unsigned PADW  = DIV_MAXW + 1 - XLEN;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              dvd_neg_q, dvd_neg_d;
    logic              dvs_neg_q, dvs_neg_d;
    logic              dzero_q, dzero_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   dvd_raw_q, dvd_raw_d;
    logic [XLEN:0]     dvs_mag_q, dvs_mag_d;
    logic [2*XLEN-1:0] pr_q, pr_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              is_signed, in_dvd_neg, in_dvs_neg, in_dzero, in_ovf, early, accept;
    logic [XLEN-1:0]   in_dvd_mag;
    logic [XLEN:0]     in_dvs_mag;
    logic [2*XLEN-1:0] step_pr;
    logic [STEP-1:0]   step_q;
    logic [XLEN-1:0]   rem_mag, fix_res;

    assign is_signed  = bus.op_i[2] & ~bus.op_i[0];
    assign in_dvd_neg = is_signed & bus.dividend_i[XLEN-1];
    assign in_dvs_neg = is_signed & bus.divisor_i[XLEN-1];
    assign in_dvd_mag = XLEN'(div_abs({{PADW{in_dvd_neg}}, bus.dividend_i}, is_signed));
    assign in_dvs_mag = (XLEN+1)'(div_abs({{PADW{in_dvs_neg}}, bus.divisor_i}, is_signed));
    assign in_dzero   = (bus.divisor_i == '0);
    assign in_ovf     = is_signed & (bus.dividend_i == MIN_VAL) & (bus.divisor_i == '1);
    assign accept     = bus.req_valid_i & ~bus.flush_i;

`ifdef DIV_ITER_EARLY_OUT_EN
    assign early = in_dzero | in_ovf | ({1'b0, in_dvd_mag} < in_dvs_mag);
`else
    assign early = 1'b0;
`endif

    div_iter_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
        .pr_i  (pr_q),
        .dvs_i (dvs_mag_q),
        .pr_o  (step_pr),
        .q_o   (step_q)
    );

    assign rem_mag = pr_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = '0;
        if (op_q[2]) begin
            if (dzero_q)      fix_res = op_q[1] ? dvd_raw_q : '1;
            else if (ovf_q)   fix_res = op_q[1] ? '0 : MIN_VAL;
            else if (op_q[1]) fix_res = dvd_neg_q ? -rem_mag : rem_mag;
            else              fix_res = (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        tag_d     = tag_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        dzero_d   = dzero_q;
        ovf_d     = ovf_q;
        dvd_raw_d = dvd_raw_q;
        dvs_mag_d = dvs_mag_q;
        pr_d      = pr_q;
        quo_d     = quo_q;
        res_d     = res_q;
        unique case (state_q)
            DIV_ST_IDLE: begin
                if (accept) begin
                    op_d      = bus.op_i;
                    tag_d     = bus.tag_i;
                    dvd_neg_d = in_dvd_neg;
                    dvs_neg_d = in_dvs_neg;
                    dzero_d   = in_dzero;
                    ovf_d     = in_ovf;
                    dvd_raw_d = bus.dividend_i;
                    dvs_mag_d = in_dvs_mag;
                    quo_d     = '0;
                    state_d   = DIV_ST_CALC;
                    // Early-out enters the final fix-up cycle directly with the
                    // dividend preloaded as remainder, so quotient stays 0.
                    if (early) begin
                        cnt_d = CNT_W'(NCYC);
                        pr_d  = {in_dvd_mag, {XLEN{1'b0}}};
                    end else begin
                        cnt_d = '0;
                        pr_d  = {{XLEN{1'b0}}, in_dvd_mag};
                    end
                end
            end
            DIV_ST_CALC: begin
                if (cnt_q == CNT_W'(NCYC)) begin
                    res_d   = fix_res;
                    state_d = DIV_ST_DONE;
                end else begin
                    pr_d  = step_pr;
                    quo_d = {quo_q[XLEN-STEP-1:0], step_q};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIV_ST_DONE: begin
                if (bus.res_ready_i) state_d = DIV_ST_IDLE;
            end
            default: state_d = DIV_ST_IDLE;
        endcase
        if (bus.flush_i) state_d = DIV_ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            tag_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            dzero_q   <= 1'b0;
            ovf_q     <= 1'b0;
            dvd_raw_q <= '0;
            dvs_mag_q <= '0;
            pr_q      <= '0;
            quo_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            dzero_q   <= dzero_d;
            ovf_q     <= ovf_d;
            dvd_raw_q <= dvd_raw_d;
            dvs_mag_q <= dvs_mag_d;
            pr_q      <= pr_d;
            quo_q     <= quo_d;
            res_q     <= res_d;
        end
    end

    assign bus.req_ready_o = (state_q == DIV_ST_IDLE);
    assign bus.res_valid_o = (state_q == DIV_ST_DONE);
    assign bus.busy_o      = (state_q != DIV_ST_IDLE);
    assign bus.res_o       = res_q;
    assign bus.tag_o       = tag_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter (XLEN=32, STEP=1); latency
// expectations follow DIV_ITER_EARLY_OUT_EN when the bench is built with it.
module tb_div_iter;
    import div_pkg::*;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned STEP     = 1;
    localparam int unsigned TAG_W    = 5;
    localparam int unsigned FULL_LAT = XLEN / STEP + 1;
`ifdef DIV_ITER_EARLY_OUT_EN
    localparam bit EO_EN = 1'b1;
`else
    localparam bit EO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_iter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    div_iter #(.XLEN(XLEN), .STEP(STEP), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    function automatic int unsigned lat_for(input logic eo);
        return (eo && EO_EN) ? 1 : FULL_LAT;
    endfunction

    task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag);
        bus.req_valid_i = 1'b1;
        bus.op_i        = op;
        bus.dividend_i  = a;
        bus.divisor_i   = b;
        bus.tag_i       = tag;
    endtask

    // Waits (bounded) for res_valid_o, counting edges since acceptance.
    task automatic wait_result(output int unsigned cyc);
        cyc = 0;
        while (bus.res_valid_o !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp, input logic eo);
        int unsigned cyc;
        @(negedge clk);
        check({name, " ready"}, 32'(bus.req_ready_o), 32'd1);
        present(op, a, b, tag);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        wait_result(cyc);
        check({name, " lat"}, cyc, lat_for(eo));
        check({name, " res"}, bus.res_o, exp);
        check({name, " tag"}, 32'(bus.tag_o), 32'(tag));
        @(negedge clk);
        bus.res_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.res_ready_i = 1'b0;
        check({name, " drop"}, 32'(bus.res_valid_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned cyc;
        int unsigned highs;
        bus.flush_i     = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.op_i        = '0;
        bus.dividend_i  = '0;
        bus.divisor_i   = '0;
        bus.tag_i       = '0;
        bus.res_ready_i = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst ready", 32'(bus.req_ready_o), 32'd1);
        check("rst valid", 32'(bus.res_valid_o), 32'd0);
        check("rst res",   bus.res_o, 32'd0);
        check("rst tag",   32'(bus.tag_o), 32'd0);
        check("rst busy",  32'(bus.busy_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("divu 100/7",  DIV_OP_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 1'b0);
        run("remu 100/7",  DIV_OP_REMU, 32'd100, 32'd7, 5'd2, 32'd2, 1'b0);
        run("div -7/2",    DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 1'b0);
        run("rem -7/2",    DIV_OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 1'b0);
        run("div 7/-2",    DIV_OP_DIV,  32'd7, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFD, 1'b0);
        run("rem 7/-2",    DIV_OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd6, 32'd1, 1'b0);
        run("div 5/0",     DIV_OP_DIV,  32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 1'b1);
        run("remu 5/0",    DIV_OP_REMU, 32'd5, 32'd0, 5'd8, 32'd5, 1'b1);
        run("div ovf",     DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1'b1);
        run("rem ovf",     DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 1'b1);
        run("divu 3/10",   DIV_OP_DIVU, 32'd3, 32'd10, 5'd11, 32'd0, 1'b1);
        run("remu 3/10",   DIV_OP_REMU, 32'd3, 32'd10, 5'd12, 32'd3, 1'b1);
        run("rem -3/10",   DIV_OP_REM,  32'hFFFF_FFFD, 32'd10, 5'd13, 32'hFFFF_FFFD, 1'b1);
        run("divu max/1",  DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd14, 32'hFFFF_FFFF, 1'b0);
        run("remu max/10", DIV_OP_REMU, 32'hFFFF_FFFF, 32'd10, 5'd15, 32'd5, 1'b0);
        run("div min/2",   DIV_OP_DIV,  32'h8000_0000, 32'd2, 5'd16, 32'hC000_0000, 1'b0);
        run("divu min/min",DIV_OP_DIVU, 32'h8000_0000, 32'h8000_0000, 5'd17, 32'd1, 1'b0);
        run("div min/3",   DIV_OP_DIV,  32'h8000_0000, 32'd3, 5'd18, 32'hD555_5556, 1'b0);
        run("rem min/3",   DIV_OP_REM,  32'h8000_0000, 32'd3, 5'd19, 32'hFFFF_FFFE, 1'b0);
        run("illegal op",  3'b000,      32'd10, 32'd3, 5'd20, 32'd0, 1'b0);

        // Result held under back-pressure, then no same-cycle re-acceptance.
        @(negedge clk);
        present(DIV_OP_DIVU, 32'd100, 32'd7, 5'd17);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        wait_result(cyc);
        check("stall lat", cyc, FULL_LAT);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall valid", 32'(bus.res_valid_o), 32'd1);
            check("stall res",   bus.res_o, 32'd14);
            check("stall tag",   32'(bus.tag_o), 32'd17);
            check("stall ready", 32'(bus.req_ready_o), 32'd0);
        end
        @(negedge clk);
        bus.res_ready_i = 1'b1;
        present(DIV_OP_DIVU, 32'd9, 32'd3, 5'd22);
        @(posedge clk); #1;
        bus.res_ready_i = 1'b0;
        check("release valid", 32'(bus.res_valid_o), 32'd0);
        check("release busy",  32'(bus.busy_o), 32'd0);
        check("release ready", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        check("next accepted", 32'(bus.busy_o), 32'd1);
        wait_result(cyc);
        check("next lat", cyc, FULL_LAT);
        check("next res", bus.res_o, 32'd3);
        check("next tag", 32'(bus.tag_o), 32'd22);
        @(negedge clk);
        bus.res_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.res_ready_i = 1'b0;

        // Flush mid-CALC with a competing request that must be ignored.
        @(negedge clk);
        present(DIV_OP_DIVU, 32'd1000, 32'd7, 5'd9);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        present(DIV_OP_DIVU, 32'd50, 32'd5, 5'd30);
        @(posedge clk); #1;
        check("flush valid", 32'(bus.res_valid_o), 32'd0);
        check("flush ready", 32'(bus.req_ready_o), 32'd1);
        check("flush busy",  32'(bus.busy_o), 32'd0);
        check("flush tag",   32'(bus.tag_o), 32'd9);
        @(negedge clk);
        bus.flush_i     = 1'b0;
        bus.req_valid_i = 1'b0;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid_o !== 1'b0) highs++;
        end
        check("flush quiet", highs, 32'd0);
        run("post-flush 9/3", DIV_OP_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 1'b0);

        // Synchronous reset mid-CALC.
        @(negedge clk);
        present(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd11);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid rst ready", 32'(bus.req_ready_o), 32'd1);
        check("mid rst valid", 32'(bus.res_valid_o), 32'd0);
        check("mid rst res",   bus.res_o, 32'd0);
        check("mid rst tag",   32'(bus.tag_o), 32'd0);
        check("mid rst busy",  32'(bus.busy_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("post-rst 100/7", DIV_OP_DIVU, 32'd100, 32'd7, 5'd31, 32'd14, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
